// File: rtl/ila_reader_pkg.sv
// Shared types and constants for the ILA sample reader (FSM state encoding, sync byte, counter width).
package ila_reader_pkg;
  localparam int         CNT_W     = 16;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {IDLE, HDR, POP, WAIT, SEND, FIN} state_t;
endpackage

// File: rtl/ila_sample_reader_if.sv
// FIFO read port and byte-stream port of the ILA sample reader, bundled with reader/environment views.
interface ila_sample_reader_if #(
  parameter int WIDTH = 20
);
  // Byte stream: a byte moves on any rising clock where byte_valid_o && byte_ready_i; once
  // byte_valid_o is high, byte_o and byte_valid_o hold until that transfer happens.
  logic             fifo_pop_o;
  logic             fifo_empty_i;
  logic [WIDTH-1:0] fifo_do_i;
  logic [7:0]       byte_o;
  logic             byte_valid_o;
  logic             byte_ready_i;

  modport master (
    output fifo_pop_o, byte_o, byte_valid_o,
    input  fifo_empty_i, fifo_do_i, byte_ready_i
  );

  modport slave (
    input  fifo_pop_o, byte_o, byte_valid_o,
    output fifo_empty_i, fifo_do_i, byte_ready_i
  );
endinterface

// File: rtl/ila_byte_serializer.sv
// Holds one word and presents it LSB byte first through a registered valid/ready output.
module ila_byte_serializer #(
  parameter int BUF_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [BUF_W-1:0] i_data,
  input  logic [7:0]       i_len,
  input  logic             i_ready,
  output logic [7:0]       o_byte,
  output logic             o_valid,
  output logic             o_last
);
  logic [BUF_W-1:0] r_buf;
  logic [7:0]       r_idx;
  logic [7:0]       r_len;
  logic             r_valid;
  logic             w_xfer;

  assign w_xfer  = r_valid && i_ready;
  assign o_last  = w_xfer && (r_idx == r_len - 8'd1);
  assign o_byte  = r_buf[7:0];
  assign o_valid = r_valid;

  // The buffer shifts down one byte per transfer, so the current byte is always in bits [7:0].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf   <= '0;
      r_idx   <= '0;
      r_len   <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_buf   <= i_data;
      r_idx   <= '0;
      r_len   <= i_len;
      r_valid <= 1'b1;
    end else if (w_xfer) begin
      if (o_last) begin
        r_valid <= 1'b0;
      end else begin
        r_buf <= r_buf >> 8;
        r_idx <= r_idx + 8'd1;
      end
    end
  end
endmodule

// File: rtl/ila_sample_reader.sv
// Drains the ILA sample FIFO and serializes each sample into bytes for the host link.
// Define ILA_READER_SYNC_HDR_EN to prefix every burst with SYNC_BYTE and the bytes-per-sample.
module ila_sample_reader
  import ila_reader_pkg::*;
#(
  parameter int WIDTH    = 20,
  parameter int READ_LAT = 2
) (
  input  logic             rclk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [CNT_W-1:0] max_samples_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] sample_cnt_o,
  output state_t           dbg_state_o,
  ila_sample_reader_if.master bus
);
  localparam int         NBYTES    = (WIDTH + 7) / 8;
  localparam int         BUF_BYTES = (NBYTES < 2) ? 2 : NBYTES;
  localparam int         BUF_W     = BUF_BYTES * 8;
  localparam logic [7:0] LAT_LAST  = 8'(READ_LAT - 1);

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt, r_limit;
  logic [7:0]       r_lat;
  logic             w_pop, w_cap, w_hdr_load, w_stop, w_last;
  logic [BUF_W-1:0] w_ld_data;
  logic [7:0]       w_ld_len;

  assign w_stop = ((r_limit != '0) && (r_cnt == r_limit)) || bus.fifo_empty_i;

  always_comb begin
    w_next     = r_state;
    w_pop      = 1'b0;
    w_cap      = 1'b0;
    w_hdr_load = 1'b0;
    case (r_state)
      IDLE: if (start_i) begin
`ifdef ILA_READER_SYNC_HDR_EN
        w_next     = HDR;
        w_hdr_load = 1'b1;
`else
        w_next     = POP;
`endif
      end
      HDR:  if (w_last) w_next = POP;
      POP:  begin
        if (w_stop) begin
          w_next = FIN;
        end else begin
          w_pop  = 1'b1;
          w_next = WAIT;
        end
      end
      WAIT: if (r_lat == LAT_LAST) begin
        w_cap  = 1'b1;
        w_next = SEND;
      end
      SEND: if (w_last) w_next = POP;
      FIN:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // The serializer is shared by the header word and by captured samples.
  always_comb begin
    w_ld_data = BUF_W'(bus.fifo_do_i);
    w_ld_len  = 8'(NBYTES);
    if (w_hdr_load) begin
      w_ld_data = BUF_W'({8'(NBYTES), SYNC_BYTE});
      w_ld_len  = 8'd2;
    end
  end

  always_ff @(posedge rclk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_limit <= '0;
      r_lat   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && start_i) begin
        r_cnt   <= '0;
        r_limit <= max_samples_i;
      end else if (w_cap) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_pop)                r_lat <= '0;
      else if (r_state == WAIT) r_lat <= r_lat + 8'd1;
    end
  end

  ila_byte_serializer #(.BUF_W(BUF_W)) u_ser (
    .clk     (rclk),
    .rst     (rst),
    .i_load  (w_cap || w_hdr_load),
    .i_data  (w_ld_data),
    .i_len   (w_ld_len),
    .i_ready (bus.byte_ready_i),
    .o_byte  (bus.byte_o),
    .o_valid (bus.byte_valid_o),
    .o_last  (w_last)
  );

  assign bus.fifo_pop_o = w_pop;
  assign busy_o         = (r_state == HDR) || (r_state == POP) || (r_state == WAIT) || (r_state == SEND);
  assign done_o         = (r_state == FIN);
  assign sample_cnt_o   = r_cnt;
  assign dbg_state_o    = r_state;
endmodule

// File: tb/tb_ila_sample_reader.sv
// Bench for ila_sample_reader: FIFO model with read latency, byte-stream scoreboard, burst scenarios.
module tb_ila_sample_reader;
  import ila_reader_pkg::*;

  localparam int WIDTH    = 20;
  localparam int READ_LAT = 2;
  localparam int NBYTES   = (WIDTH + 7) / 8;
  localparam int PW       = NBYTES * 8;
`ifdef ILA_READER_SYNC_HDR_EN
  localparam int HDR_N = 2;
`else
  localparam int HDR_N = 0;
`endif

  logic        rclk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [15:0] max_samples_i = '0;
  logic        busy_o, done_o;
  logic [15:0] sample_cnt_o;
  state_t      dbg_state;

  ila_sample_reader_if #(.WIDTH(WIDTH)) bus ();

  ila_sample_reader #(.WIDTH(WIDTH), .READ_LAT(READ_LAT)) dut (
    .rclk          (rclk),
    .rst           (rst),
    .start_i       (start_i),
    .max_samples_i (max_samples_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .sample_cnt_o  (sample_cnt_o),
    .dbg_state_o   (dbg_state),
    .bus           (bus.master)
  );

  // clock / reset
  always #5 rclk = ~rclk;

  logic [WIDTH-1:0] fifo_q[$];
  logic [WIDTH-1:0] mdl_q[$];
  logic [7:0]       exp_q[$];
  logic [7:0]       lit_q[$];
  logic [WIDTH-1:0] d1 = '0;
  int checks = 0, failures = 0;
  int xfer_cnt = 0, pop_cnt = 0, done_cnt = 0, hold_left = 0;
  bit rdy_rand = 1'b0, pop_pend = 1'b0, prev_pop = 1'b0, prev_v = 1'b0, prev_r = 1'b0;
  logic [7:0] prev_b = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // FIFO with a two-register read path: data appears READ_LAT cycles after the pop
  always @(posedge rclk) begin
    if (pop_pend && fifo_q.size() > 0) d1 <= fifo_q.pop_front();
    bus.fifo_do_i    <= d1;
    bus.fifo_empty_i <= (fifo_q.size() == 0);
  end

  // sink ready driver
  initial begin
    bus.byte_ready_i = 1'b0;
    forever begin
      @(posedge rclk);
      #2;
      if (hold_left > 0) begin
        bus.byte_ready_i = 1'b0;
        hold_left--;
      end else if (rdy_rand) begin
        bus.byte_ready_i = 1'($urandom_range(0, 1));
      end else begin
        bus.byte_ready_i = 1'b1;
      end
    end
  end

  // scoreboard / per-cycle compare
  always @(negedge rclk) begin
    if (rst) begin
      prev_v = 1'b0; pop_pend = 1'b0; prev_pop = 1'b0;
    end else begin
      if (prev_v && !prev_r) begin
        check("hold_valid", bus.byte_valid_o, 1);
        check("hold_byte", bus.byte_o, prev_b);
      end
      if (bus.byte_valid_o) check("valid_in_busy", busy_o, 1);
      if (bus.byte_valid_o && bus.byte_ready_i) begin
        xfer_cnt++;
        check("byte_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("byte_value", bus.byte_o, exp_q.pop_front());
      end
      if (bus.fifo_pop_o) begin
        pop_cnt++;
        check("pop_nonempty", fifo_q.size() != 0, 1);
        check("pop_single", prev_pop, 0);
      end
      if (done_o) begin
        done_cnt++;
        check("done_not_busy", busy_o, 0);
      end
      pop_pend = bus.fifo_pop_o;
      prev_pop = bus.fifo_pop_o;
      prev_v   = bus.byte_valid_o;
      prev_r   = bus.byte_ready_i;
      prev_b   = bus.byte_o;
    end
  end

  task automatic load(input logic [WIDTH-1:0] v);
    fifo_q.push_back(v);
    mdl_q.push_back(v);
  endtask

  task automatic add_sample(input logic [WIDTH-1:0] s);
    logic [PW-1:0] p;
    p = PW'(s);
    for (int b = 0; b < NBYTES; b++) exp_q.push_back(p[8*b +: 8]);
  endtask

  task automatic add_header();
`ifdef ILA_READER_SYNC_HDR_EN
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'(NBYTES));
`endif
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_pop"}, bus.fifo_pop_o, 0);
    check({tag, "_valid"}, bus.byte_valid_o, 0);
    check({tag, "_byte"}, bus.byte_o, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_cnt"}, sample_cnt_o, 0);
    check({tag, "_state"}, dbg_state, IDLE);
  endtask

  task automatic run_burst(input logic [15:0] mx, input int bound, input int hold_after,
                           input bit mid_start, input bit pin);
    int n, p0, d0, x0, rem;
    bit seen, hold_done;
    seen = 1'b0; hold_done = 1'b0;
    n = (mx == 0 || mdl_q.size() < int'(mx)) ? mdl_q.size() : int'(mx);
    add_header();
    for (int k = 0; k < n; k++) add_sample(mdl_q.pop_front());
    rem = mdl_q.size();
    if (pin) begin
      check("pin_len", exp_q.size(), lit_q.size());
      for (int i = 0; i < lit_q.size() && i < exp_q.size(); i++) check("pin_byte", exp_q[i], lit_q[i]);
    end
    p0 = pop_cnt; d0 = done_cnt; x0 = xfer_cnt;
    @(posedge rclk); #1;
    max_samples_i = mx;
    start_i = 1'b1;
    @(posedge rclk); #1;
    start_i = 1'b0;
    max_samples_i = 16'($urandom);
    check("busy_after_start", busy_o, 1);
    for (int c = 0; c < bound && !seen; c++) begin
      @(posedge rclk); #1;
      start_i = (mid_start && c == 8);
      if (mid_start && c == 8) max_samples_i = 16'd1;
      if (hold_after >= 0 && !hold_done && (xfer_cnt - x0) >= hold_after) begin
        hold_left = 5;
        hold_done = 1'b1;
      end
      if (done_cnt != d0) seen = 1'b1;
    end
    start_i = 1'b0;
    check("done_seen", seen, 1);
    check("sample_cnt", sample_cnt_o, 16'(n));
    check("pops", pop_cnt - p0, n);
    check("bytes_left", exp_q.size(), 0);
    check("fifo_left", fifo_q.size(), rem);
    check("busy_after_done", busy_o, 0);
    repeat (3) @(posedge rclk);
    #1;
    check("one_done", done_cnt - d0, 1);
    exp_q.delete();
  endtask

  initial begin
    int k, x0;
    logic [15:0] mx;
    repeat (3) @(posedge rclk);
    #1;
    check_zero_outputs("reset");
    rst = 1'b0;

    // three known samples, unlimited
`ifdef ILA_READER_SYNC_HDR_EN
    lit_q = {8'hA5, 8'h03, 8'hDE, 8'hBC, 8'h0A, 8'h45, 8'h23, 8'h01, 8'h0F, 8'h0F, 8'h00};
`else
    lit_q = {8'hDE, 8'hBC, 8'h0A, 8'h45, 8'h23, 8'h01, 8'h0F, 8'h0F, 8'h00};
`endif
    load(20'hABCDE); load(20'h12345); load(20'h00F0F);
    run_burst(16'd0, 300, -1, 1'b0, 1'b1);

    // ten samples, limit four, with a stray start mid-burst
    for (int i = 0; i < 10; i++) load(WIDTH'($urandom));
    run_burst(16'd4, 400, -1, 1'b1, 1'b0);
    check("limit_remaining", fifo_q.size(), 6);
    rdy_rand = 1'b1;
    run_burst(16'd0, 1500, -1, 1'b0, 1'b0);
    rdy_rand = 1'b0;

    // empty FIFO
    run_burst(16'd0, 3 + HDR_N, -1, 1'b0, 1'b0);

    // ready held low mid-sample
    load(20'h5A5A5); load(20'hC3C3C);
    run_burst(16'd0, 300, 1, 1'b0, 1'b0);

    // reset while a sample is being sent
    for (int i = 0; i < 5; i++) load(WIDTH'($urandom));
    add_header();
    foreach (mdl_q[i]) add_sample(mdl_q[i]);
    x0 = xfer_cnt;
    @(posedge rclk); #1;
    max_samples_i = 16'd0;
    start_i = 1'b1;
    @(posedge rclk); #1;
    start_i = 1'b0;
    k = 0;
    while (k < 300 && (xfer_cnt - x0) < HDR_N + 4) begin
      @(posedge rclk);
      k++;
    end
    check("abort_reached", (xfer_cnt - x0), HDR_N + 4);
    #1;
    rst = 1'b1;
    #1;
    check_zero_outputs("abort");
    check("abort_fifo_left", fifo_q.size(), 3);
    void'(mdl_q.pop_front());
    void'(mdl_q.pop_front());
    exp_q.delete();
    repeat (2) @(posedge rclk);
    #1;
    rst = 1'b0;
    run_burst(16'd0, 300, -1, 1'b0, 1'b0);

    // randomized bursts
    rdy_rand = 1'b1;
    for (int it = 0; it < 8; it++) begin
      k = $urandom_range(0, 7);
      for (int i = 0; i < k; i++) load(WIDTH'($urandom));
      mx = 16'($urandom_range(0, 5));
      run_burst(mx, 1500, -1, 1'b0, 1'b0);
    end
    run_burst(16'd0, 3000, -1, 1'b0, 1'b0);
    rdy_rand = 1'b0;

`ifdef ILA_READER_SYNC_HDR_EN
    lit_q = {8'hA5, 8'h03, 8'h01, 8'h00, 8'h00};
    load(20'h00001);
    run_burst(16'd0, 300, -1, 1'b0, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
